alarm_zone_controller: RTL and testbench

- Sequential, parametrised successor to the single-zone S/P/V-to-LED indicator logic.
- Monitors NUM_ZONES sensor zones. Each zone has a presence input (p) and a vibration input (v), and each input is debounced.
- An arming state machine with an exit delay drives a status LED (off, slow blink, steady, fast blink), a siren output and per-zone latched alarm flags.
- Sits between raw panel inputs and the indicator/annunciator outputs.

---
 rtl/alarm_pkg.sv | 20 ++
 rtl/input_debounce.sv | 33 +++
 rtl/alarm_zone_controller.sv | 132 +++++++++++++
 tb/tb_alarm_zone_controller.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared constants for the multi-zone alarm controller.
// State codes, LED levels and the FSM state type.
package alarm_pkg;

    localparam logic [1:0] ST_DISARMED = 2'd0;
    localparam logic [1:0] ST_ARMING   = 2'd1;
    localparam logic [1:0] ST_ARMED    = 2'd2;
    localparam logic [1:0] ST_ALARM    = 2'd3;

    localparam logic LED_OFF = 1'b0;
    localparam logic LED_ON  = 1'b1;

    typedef enum logic [1:0] {
        DISARMED = ST_DISARMED,
        ARMING   = ST_ARMING,
        ARMED    = ST_ARMED,
        ALARM    = ST_ALARM
    } state_t;

endpackage

// File: rtl/input_debounce.sv
// Single-bit debounce filter: the output follows the raw input
// only after DEBOUNCE_CYCLES consecutive differing samples.
module input_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db
);

    localparam int CW =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Count consecutive disagreements; flip once the run is long enough
    always_ff @(posedge clk) begin
        if (rst) begin
            db  <= 1'b0;
            cnt <= '0;
        end else if (raw == db) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            db  <= raw;
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/alarm_zone_controller.sv
// Multi-zone alarm controller: debounced sensors, arming FSM
// with exit delay, blinking status LED, siren and zone latch.
module alarm_zone_controller
    import alarm_pkg::*;
#(
    parameter int NUM_ZONES       = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int EXIT_DELAY      = 16,
    parameter int BLINK_HALF      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arm,
    input  logic [NUM_ZONES-1:0] p,
    input  logic [NUM_ZONES-1:0] v,
    input  logic [NUM_ZONES-1:0] zone_mask,
    output logic                 led,
    output logic                 siren,
    output logic [NUM_ZONES-1:0] alarm_zones,
    output logic [1:0]           state
);

    localparam int BW = $clog2(BLINK_HALF);
    localparam logic [BW-1:0] SLOW_LAST = BW'(BLINK_HALF - 1);
    localparam logic [BW-1:0] FAST_LAST = BW'(BLINK_HALF / 2 - 1);
    localparam logic [15:0]   EXIT_LAST = 16'(EXIT_DELAY - 1);

    logic [NUM_ZONES-1:0] p_db;
    logic [NUM_ZONES-1:0] v_db;
    logic [NUM_ZONES-1:0] trig;

    state_t        st;
    logic [15:0]   exit_cnt;
    logic [BW-1:0] blink_cnt;

    for (genvar i = 0; i < NUM_ZONES; i++) begin : g_zone
        input_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_p_db (
            .clk(clk),
            .rst(rst),
            .raw(p[i]),
            .db (p_db[i])
        );
        input_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_v_db (
            .clk(clk),
            .rst(rst),
            .raw(v[i]),
            .db (v_db[i])
        );
    end

    assign trig  = (p_db | v_db) & zone_mask;
    assign state = st;

    // Arming FSM with exit delay, blink timing and zone latch
    always_ff @(posedge clk) begin
        if (rst) begin
            st          <= DISARMED;
            led         <= LED_OFF;
            siren       <= 1'b0;
            alarm_zones <= '0;
            exit_cnt    <= '0;
            blink_cnt   <= '0;
        end else begin
            unique case (st)
                DISARMED: begin
                    if (arm) begin
                        st          <= ARMING;
                        alarm_zones <= '0;
                        exit_cnt    <= '0;
                        blink_cnt   <= '0;
                        led         <= LED_ON;
                    end
                end
                ARMING: begin
                    if (!arm) begin
                        st        <= DISARMED;
                        led       <= LED_OFF;
                        siren     <= 1'b0;
                        blink_cnt <= '0;
                    end else if (exit_cnt == EXIT_LAST) begin
                        st        <= ARMED;
                        led       <= LED_ON;
                        blink_cnt <= '0;
                    end else begin
                        exit_cnt <= exit_cnt + 16'd1;
                        if (blink_cnt == SLOW_LAST) begin
                            led       <= ~led;
                            blink_cnt <= '0;
                        end else begin
                            blink_cnt <= blink_cnt + BW'(1);
                        end
                    end
                end
                ARMED: begin
                    if (!arm) begin
                        st        <= DISARMED;
                        led       <= LED_OFF;
                        siren     <= 1'b0;
                        blink_cnt <= '0;
                    end else if (|trig) begin
                        st          <= ALARM;
                        led         <= LED_ON;
                        siren       <= 1'b1;
                        blink_cnt   <= '0;
                        alarm_zones <= alarm_zones | trig;
                    end
                end
                ALARM: begin
                    if (!arm) begin
                        st        <= DISARMED;
                        led       <= LED_OFF;
                        siren     <= 1'b0;
                        blink_cnt <= '0;
                    end else begin
                        alarm_zones <= alarm_zones | trig;
                        if (blink_cnt == FAST_LAST) begin
                            led       <= ~led;
                            blink_cnt <= '0;
                        end else begin
                            blink_cnt <= blink_cnt + BW'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_zone_controller.sv
// Directed bench for alarm_zone_controller with a behavioural
// model compared every cycle plus literal spot checks.
module tb_alarm_zone_controller;

    localparam int NZ = 4;
    localparam int DC = 4;
    localparam int ED = 16;
    localparam int BH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          arm;
    logic [NZ-1:0] p;
    logic [NZ-1:0] v;
    logic [NZ-1:0] zone_mask;
    logic          led;
    logic          siren;
    logic [NZ-1:0] alarm_zones;
    logic [1:0]    state;

    int checks   = 0;
    int failures = 0;
    bit started  = 0;

    // Model state: FSM state, cycles spent in it, zone record
    int            m_st;
    int            m_tis;
    logic [NZ-1:0] m_zones;
    // Model debouncers: index 0..NZ-1 are p, NZ..2NZ-1 are v
    logic          m_db   [2*NZ];
    logic          m_prev [2*NZ];
    int            m_run  [2*NZ];
    logic [NZ-1:0] m_trig;
    logic          m_raw;

    alarm_zone_controller #(
        .NUM_ZONES      (NZ),
        .DEBOUNCE_CYCLES(DC),
        .EXIT_DELAY     (ED),
        .BLINK_HALF     (BH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm),
        .p          (p),
        .v          (v),
        .zone_mask  (zone_mask),
        .led        (led),
        .siren      (siren),
        .alarm_zones(alarm_zones),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int exp_led();
        case (m_st)
            1:       return ((m_tis / BH) % 2 == 0) ? 1 : 0;
            2:       return 1;
            3:       return ((m_tis / (BH / 2)) % 2 == 0) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    // Behavioural model, advanced on each rising edge
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_st    = 0;
                m_tis   = 0;
                m_zones = '0;
                for (int i = 0; i < 2*NZ; i++) begin
                    m_db[i]   = 1'b0;
                    m_prev[i] = 1'b0;
                    m_run[i]  = 0;
                end
            end else begin
                for (int i = 0; i < NZ; i++)
                    m_trig[i] = (m_db[i] | m_db[NZ+i]) & zone_mask[i];
                case (m_st)
                    0: begin
                        if (arm) begin
                            m_st = 1; m_tis = 0; m_zones = '0;
                        end else m_tis++;
                    end
                    1: begin
                        if (!arm) begin
                            m_st = 0; m_tis = 0;
                        end else if (m_tis == ED - 1) begin
                            m_st = 2; m_tis = 0;
                        end else m_tis++;
                    end
                    2: begin
                        if (!arm) begin
                            m_st = 0; m_tis = 0;
                        end else if (m_trig != 0) begin
                            m_st = 3; m_tis = 0;
                            m_zones = m_zones | m_trig;
                        end else m_tis++;
                    end
                    default: begin
                        if (!arm) begin
                            m_st = 0; m_tis = 0;
                        end else begin
                            m_zones = m_zones | m_trig;
                            m_tis++;
                        end
                    end
                endcase
                // A level change is accepted after DC identical samples
                for (int i = 0; i < 2*NZ; i++) begin
                    m_raw = (i < NZ) ? p[i] : v[i-NZ];
                    m_run[i] = (m_raw == m_prev[i]) ? m_run[i] + 1 : 1;
                    m_prev[i] = m_raw;
                    if (m_raw != m_db[i] && m_run[i] >= DC)
                        m_db[i] = m_raw;
                end
            end
            started = 1;
        end
    end

    // Every-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                chk("m_state", int'(state), m_st);
                chk("m_led", int'(led), exp_led());
                chk("m_siren", int'(siren), (m_st == 3) ? 1 : 0);
                chk("m_zones", int'(alarm_zones), int'(m_zones));
            end
        end
    end

    // Directed stimulus with literal expectations
    initial begin
        rst = 1'b1; arm = 1'b1;
        p = 4'hF; v = 4'hA; zone_mask = 4'hF;
        tick(2);
        chk("rst_state", int'(state), 0);
        chk("rst_led", int'(led), 0);
        chk("rst_siren", int'(siren), 0);
        chk("rst_zones", int'(alarm_zones), 0);
        rst = 1'b0; arm = 1'b0; p = 4'h0; v = 4'h0;
        tick(50);
        chk("idle_state", int'(state), 0);
        chk("idle_led", int'(led), 0);

        arm = 1'b1;
        tick(1);
        chk("arming_enter", int'(state), 1);
        chk("arming_led_on", int'(led), 1);
        tick(7);
        chk("arming_led_c8", int'(led), 1);
        tick(1);
        chk("arming_led_off", int'(led), 0);
        tick(7);
        chk("arming_last", int'(state), 1);
        tick(1);
        chk("armed_enter", int'(state), 2);
        chk("armed_led", int'(led), 1);

        p = 4'b0010;
        tick(3);
        p = 4'b0000;
        tick(10);
        chk("glitch_armed", int'(state), 2);
        zone_mask = 4'b1110; p = 4'b0001;
        tick(10);
        chk("mask_armed", int'(state), 2);
        chk("mask_zones", int'(alarm_zones), 0);
        p = 4'b0000;
        tick(5);
        zone_mask = 4'hF;

        v = 4'b0100;
        tick(4);
        chk("vib_t4", int'(state), 2);
        tick(1);
        chk("vib_alarm", int'(state), 3);
        chk("vib_siren", int'(siren), 1);
        chk("vib_zones", int'(alarm_zones), 4'b0100);
        chk("vib_led", int'(led), 1);
        tick(3);
        chk("alarm_led_c4", int'(led), 1);
        tick(1);
        chk("alarm_led_off", int'(led), 0);
        p = 4'b0001;
        tick(5);
        chk("join_zones", int'(alarm_zones), 4'b0101);

        p = 4'b1001;
        tick(4);
        arm = 1'b0;
        tick(1);
        chk("disarm_state", int'(state), 0);
        chk("disarm_siren", int'(siren), 0);
        chk("disarm_led", int'(led), 0);
        chk("disarm_zones", int'(alarm_zones), 4'b0101);

        arm = 1'b1;
        tick(1);
        chk("rearm_state", int'(state), 1);
        chk("rearm_clear", int'(alarm_zones), 0);
        tick(15);
        chk("rearm_ignore", int'(state), 1);
        tick(1);
        chk("exit_armed", int'(state), 2);
        tick(1);
        chk("exit_alarm", int'(state), 3);
        chk("exit_zones", int'(alarm_zones), 4'b1101);
        arm = 1'b0; p = 4'h0; v = 4'h0;
        tick(6);

        arm = 1'b1;
        tick(8);
        chk("mid_arming", int'(state), 1);
        rst = 1'b1; arm = 1'b0;
        tick(1);
        chk("mid_rst_state", int'(state), 0);
        chk("mid_rst_zones", int'(alarm_zones), 0);
        chk("mid_rst_led", int'(led), 0);
        rst = 1'b0; arm = 1'b1;
        tick(1);
        chk("post_rst_arming", int'(state), 1);
        tick(15);
        chk("post_rst_c16", int'(state), 1);
        tick(1);
        chk("post_rst_armed", int'(state), 2);
        arm = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
